// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit for the TSC-style core: sequences IF/ID/EX/MEM/WB per
// instruction class, owns the IR, stalls on the memory handshake and traps HLT/illegal.
module multicycle_ctrl_fsm #(
    parameter int WORD_W  = 16,
    parameter int OP_W    = 4,
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WORD_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    input  logic               alu_cond,
    output logic [WORD_W-1:0]  inst,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               carry_in,
    output logic               wwd,
    output logic               retire,
    output logic               halted,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_BR_LAST = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADI     = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ORI     = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LHI     = OP_W'(6);
    localparam logic [OP_W-1:0] OP_LWD     = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SWD     = OP_W'(8);
    localparam logic [OP_W-1:0] OP_JMP     = OP_W'(9);
    localparam logic [OP_W-1:0] OP_JAL     = OP_W'(10);
    localparam logic [OP_W-1:0] OP_RTYPE   = OP_W'(15);

    localparam logic [FUNC_W-1:0] FN_TCP = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] FN_SHR = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] FN_JPR = FUNC_W'(25);
    localparam logic [FUNC_W-1:0] FN_JRL = FUNC_W'(26);
    localparam logic [FUNC_W-1:0] FN_WWD = FUNC_W'(28);
    localparam logic [FUNC_W-1:0] FN_HLT = FUNC_W'(29);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_NOT = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_ALS = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_ARS = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_LHI = ALUOP_W'(8);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic                illegal_q, illegal_d;

    logic [OP_W-1:0]     op;
    logic [FUNC_W-1:0]   func;
    logic                dec_br, dec_adi, dec_ori, dec_lhi, dec_lwd, dec_swd;
    logic                dec_jmp, dec_jal, dec_r, dec_ralu, dec_tcp;
    logic                dec_jpr, dec_jrl, dec_wwd, dec_hlt, dec_legal;
    logic [ALUOP_W-1:0]  ex_alu_op;

    // Instruction class decode from the IR; field positions follow the parameters.
    assign op        = ir_q[WORD_W-1 -: OP_W];
    assign func      = ir_q[FUNC_W-1:0];
    assign dec_br    = (op <= OP_BR_LAST);
    assign dec_adi   = (op == OP_ADI);
    assign dec_ori   = (op == OP_ORI);
    assign dec_lhi   = (op == OP_LHI);
    assign dec_lwd   = (op == OP_LWD);
    assign dec_swd   = (op == OP_SWD);
    assign dec_jmp   = (op == OP_JMP);
    assign dec_jal   = (op == OP_JAL);
    assign dec_r     = (op == OP_RTYPE);
    assign dec_ralu  = dec_r && (func <= FN_SHR);
    assign dec_tcp   = dec_r && (func == FN_TCP);
    assign dec_jpr   = dec_r && (func == FN_JPR);
    assign dec_jrl   = dec_r && (func == FN_JRL);
    assign dec_wwd   = dec_r && (func == FN_WWD);
    assign dec_hlt   = dec_r && (func == FN_HLT);
    assign dec_legal = dec_br | dec_adi | dec_ori | dec_lhi | dec_lwd | dec_swd |
                       dec_jmp | dec_jal | dec_ralu | dec_jpr | dec_jrl |
                       dec_wwd | dec_hlt;

    assign inst    = ir_q;
    assign illegal = illegal_q;

    always_comb begin
        ex_alu_op = ALU_ADD;
        if (dec_br) begin
            ex_alu_op = ALU_SUB;
        end else if (dec_ralu) begin
            // TCP shares NOT; the +1 comes from carry_in.
            case (func[2:0])
                3'd0:    ex_alu_op = ALU_ADD;
                3'd1:    ex_alu_op = ALU_SUB;
                3'd2:    ex_alu_op = ALU_AND;
                3'd3:    ex_alu_op = ALU_OR;
                3'd4:    ex_alu_op = ALU_NOT;
                3'd5:    ex_alu_op = ALU_NOT;
                3'd6:    ex_alu_op = ALU_ALS;
                default: ex_alu_op = ALU_ARS;
            endcase
        end else if (dec_ori) begin
            ex_alu_op = ALU_OR;
        end else if (dec_lhi) begin
            ex_alu_op = ALU_LHI;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IF;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        carry_in   = 1'b0;
        wwd        = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                // Reset holds this state, so keep the PC quiet until reset_n is released.
                if (mem_ready && reset_n) begin
                    ir_d     = mem_rdata;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                alu_src_b = 2'd2;
                if (!dec_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (dec_jmp || dec_jal || dec_jpr || dec_jrl) begin
                    pc_write = 1'b1;
                    pc_src   = (dec_jmp || dec_jal) ? 2'd2 : 2'd3;
                    retire   = 1'b1;
                    state_d  = S_IF;
                    if (dec_jal || dec_jrl) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end else if (dec_hlt) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else if (dec_wwd) begin
                    wwd     = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ex_alu_op;
                carry_in  = dec_tcp;
                if (dec_adi || dec_lwd || dec_swd) begin
                    alu_src_b = 2'd2;
                end else if (dec_ori || dec_lhi) begin
                    alu_src_b = 2'd3;
                end
                if (dec_br) begin
                    pc_src   = 2'd1;
                    pc_write = alu_cond;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else if (dec_lwd || dec_swd) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = dec_lwd;
                mem_write = dec_swd;
                if (mem_ready) begin
                    if (dec_swd) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = dec_r ? 2'd1 : 2'd0;
                mem_to_reg = dec_lwd ? 2'd1 : 2'd0;
                retire     = 1'b1;
                state_d    = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: table-driven vectors, directed corner sequences and
// random traffic checked against a per-instruction phase-plan model.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       carry_in;
        logic       wwd;
        logic       retire;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic [15:0] inst;
        logic        cond;
        int          lat;
        ctrl_t       last;
    } vec_t;

    localparam int P_FETCH = 0, P_DEC = 1, P_EXE = 2, P_MEM = 3, P_WB = 4, P_STOP = 5;
    localparam int K_ALU = 0, K_BR = 1, K_ADI = 2, K_ORI = 3, K_LHI = 4, K_LWD = 5, K_SWD = 6,
                   K_JMP = 7, K_JAL = 8, K_JPR = 9, K_JRL = 10, K_WWD = 11, K_HLT = 12,
                   K_BAD = 13;

    logic        clk;
    logic        reset_n;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        alu_cond;
    logic [15:0] inst;
    logic        mem_read, mem_write, i_or_d, pc_write, reg_write, alu_src_a;
    logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0]  alu_op;
    logic        carry_in, wwd, retire, halted, illegal;
    ctrl_t       dut_c;

    int total, bad;
    int plan[$];
    logic [15:0] m_ir;
    logic        m_ill;
    ctrl_t       got, expv;
    logic [15:0] got_inst;
    vec_t        vt[12];

    multicycle_ctrl_fsm #(.WORD_W(16), .OP_W(4), .FUNC_W(6), .ALUOP_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_cond(alu_cond), .inst(inst), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .carry_in(carry_in), .wwd(wwd),
        .retire(retire), .halted(halted), .illegal(illegal)
    );

    assign dut_c = {mem_read, mem_write, i_or_d, pc_write, pc_src, reg_write, reg_dst,
                    mem_to_reg, alu_src_a, alu_src_b, alu_op, carry_in, wwd, retire,
                    halted, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    function automatic ctrl_t mkc(input int mr, mw, iod, pw, ps, rw, rd, mtr, asa, asb,
                                  aop, ci, w, ret, h, il);
        ctrl_t c;
        c = '{mem_read: 1'(mr), mem_write: 1'(mw), i_or_d: 1'(iod), pc_write: 1'(pw),
              pc_src: 2'(ps), reg_write: 1'(rw), reg_dst: 2'(rd), mem_to_reg: 2'(mtr),
              alu_src_a: 1'(asa), alu_src_b: 2'(asb), alu_op: 4'(aop), carry_in: 1'(ci),
              wwd: 1'(w), retire: 1'(ret), halted: 1'(h), illegal: 1'(il)};
        return c;
    endfunction

    function automatic int kind_of(input logic [15:0] w);
        int op, f;
        op = int'(w[15:12]);
        f  = int'(w[5:0]);
        if (op <= 3) return K_BR;
        case (op)
            4: return K_ADI;
            5: return K_ORI;
            6: return K_LHI;
            7: return K_LWD;
            8: return K_SWD;
            9: return K_JMP;
            10: return K_JAL;
            15: begin
                if (f <= 7) return K_ALU;
                if (f == 25) return K_JPR;
                if (f == 26) return K_JRL;
                if (f == 28) return K_WWD;
                if (f == 29) return K_HLT;
                return K_BAD;
            end
            default: return K_BAD;
        endcase
    endfunction

    task automatic m_reset();
        plan.delete();
        m_ir  = '0;
        m_ill = 1'b0;
    endtask

    // Remaining phases after fetch, from each class's documented latency.
    task automatic m_plan(input int k);
        plan.delete();
        case (k)
            K_ALU, K_ADI, K_ORI, K_LHI: plan = '{P_DEC, P_EXE, P_WB};
            K_LWD:                      plan = '{P_DEC, P_EXE, P_MEM, P_WB};
            K_SWD:                      plan = '{P_DEC, P_EXE, P_MEM};
            K_BR:                       plan = '{P_DEC, P_EXE};
            K_HLT, K_BAD:               plan = '{P_DEC, P_STOP};
            default:                    plan = '{P_DEC};
        endcase
    endtask

    function automatic ctrl_t m_expect(input logic rdy, input logic cond);
        ctrl_t c;
        int ph, k;
        int alu_of_func[8] = '{0, 1, 2, 3, 4, 4, 6, 7};
        c = '0;
        ph = (plan.size() > 0) ? plan[0] : P_FETCH;
        k = kind_of(m_ir);
        c.illegal = m_ill;
        case (ph)
            P_FETCH: begin
                c.mem_read = 1'b1;
                c.pc_write = rdy & reset_n;
            end
            P_DEC: begin
                c.alu_src_b = 2'd2;
                if (k inside {K_JMP, K_JAL, K_JPR, K_JRL}) begin
                    c.pc_write = 1'b1;
                    c.pc_src = (k == K_JMP || k == K_JAL) ? 2'd2 : 2'd3;
                    c.retire = 1'b1;
                    if (k == K_JAL || k == K_JRL) begin
                        c.reg_write = 1'b1;
                        c.reg_dst = 2'd2;
                        c.mem_to_reg = 2'd2;
                    end
                end
                if (k == K_HLT) c.retire = 1'b1;
                if (k == K_WWD) begin
                    c.wwd = 1'b1;
                    c.retire = 1'b1;
                end
            end
            P_EXE: begin
                c.alu_src_a = 1'b1;
                case (k)
                    K_BR: begin
                        c.alu_op = 4'd1;
                        c.pc_src = 2'd1;
                        c.pc_write = cond;
                        c.retire = 1'b1;
                    end
                    K_ALU: begin
                        c.alu_op = 4'(alu_of_func[m_ir[2:0]]);
                        c.carry_in = (m_ir[5:0] == 6'd5);
                    end
                    K_ADI, K_LWD, K_SWD: c.alu_src_b = 2'd2;
                    K_ORI: begin c.alu_src_b = 2'd3; c.alu_op = 4'd3; end
                    K_LHI: begin c.alu_src_b = 2'd3; c.alu_op = 4'd8; end
                    default: ;
                endcase
            end
            P_MEM: begin
                c.i_or_d = 1'b1;
                c.mem_read = (k == K_LWD);
                c.mem_write = (k == K_SWD);
                c.retire = (k == K_SWD) && rdy;
            end
            P_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst = (k == K_ALU) ? 2'd1 : 2'd0;
                c.mem_to_reg = (k == K_LWD) ? 2'd1 : 2'd0;
                c.retire = 1'b1;
            end
            default: c.halted = 1'b1;
        endcase
        return c;
    endfunction

    task automatic m_advance(input logic [15:0] rd, input logic rdy);
        int ph;
        if (!reset_n) begin
            m_reset();
            return;
        end
        ph = (plan.size() > 0) ? plan[0] : P_FETCH;
        case (ph)
            P_FETCH: if (rdy) begin
                m_ir = rd;
                m_plan(kind_of(rd));
            end
            P_MEM:  if (rdy) void'(plan.pop_front());
            P_STOP: ;
            default: begin
                if (ph == P_DEC && kind_of(m_ir) == K_BAD) m_ill = 1'b1;
                void'(plan.pop_front());
            end
        endcase
    endtask

    // One clock: drive at edge+1, compare at edge+3, then advance the model on the edge.
    task automatic cyc(input logic [15:0] rd, input logic rdy, input logic cond,
                       input string tag);
        mem_rdata = rd;
        mem_ready = rdy;
        alu_cond  = cond;
        if (!reset_n) m_reset();
        #2;
        expv = m_expect(rdy, cond);
        got = dut_c;
        got_inst = inst;
        chk({tag, "_ctrl"}, 32'(got), 32'(expv));
        chk({tag, "_inst"}, 32'(got_inst), 32'(m_ir));
        @(posedge clk);
        m_advance(rd, rdy);
        #1;
    endtask

    function automatic logic [15:0] rand_inst();
        logic [15:0] w;
        int r;
        int ops[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};
        int fns[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 25, 26, 28};
        w = 16'($urandom);
        r = $urandom_range(0, 99);
        if (r == 0) begin
            w[15:12] = 4'($urandom_range(11, 14));
        end else if (r < 3) begin
            w[15:12] = 4'hF;
            w[5:0] = 6'($urandom_range(8, 24));
        end else if (r == 3) begin
            w[15:12] = 4'hF;
            w[5:0] = 6'd29;
        end else begin
            w[15:12] = 4'(ops[$urandom_range(0, 11)]);
            if (w[15:12] == 4'hF) w[5:0] = 6'(fns[$urandom_range(0, 10)]);
        end
        return w;
    endfunction

    initial begin
        int halt_cnt;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        alu_cond = 1'b0;
        m_reset();

        vt[0]  = '{16'hF6C0, 1'b0, 4, mkc(0,0,0,0,0, 1,1,0, 0,0,0, 0,0,1,0,0)};
        vt[1]  = '{16'h4123, 1'b0, 4, mkc(0,0,0,0,0, 1,0,0, 0,0,0, 0,0,1,0,0)};
        vt[2]  = '{16'h5123, 1'b0, 4, mkc(0,0,0,0,0, 1,0,0, 0,0,0, 0,0,1,0,0)};
        vt[3]  = '{16'h6055, 1'b0, 4, mkc(0,0,0,0,0, 1,0,0, 0,0,0, 0,0,1,0,0)};
        vt[4]  = '{16'h7102, 1'b0, 5, mkc(0,0,0,0,0, 1,0,1, 0,0,0, 0,0,1,0,0)};
        vt[5]  = '{16'h8102, 1'b0, 4, mkc(0,1,1,0,0, 0,0,0, 0,0,0, 0,0,1,0,0)};
        vt[6]  = '{16'h0105, 1'b1, 3, mkc(0,0,0,1,1, 0,0,0, 1,0,1, 0,0,1,0,0)};
        vt[7]  = '{16'h2105, 1'b0, 3, mkc(0,0,0,0,1, 0,0,0, 1,0,1, 0,0,1,0,0)};
        vt[8]  = '{16'h9010, 1'b0, 2, mkc(0,0,0,1,2, 0,0,0, 0,2,0, 0,0,1,0,0)};
        vt[9]  = '{16'hF01A, 1'b0, 2, mkc(0,0,0,1,3, 1,2,2, 0,2,0, 0,0,1,0,0)};
        vt[10] = '{16'hF01C, 1'b0, 2, mkc(0,0,0,0,0, 0,0,0, 0,2,0, 0,1,1,0,0)};
        vt[11] = '{16'hF019, 1'b0, 2, mkc(0,0,0,1,3, 0,0,0, 0,2,0, 0,0,1,0,0)};

        #1;
        cyc(16'h0000, 1'b0, 1'b0, "rst0");
        chk("rst_outputs", 32'(got), 32'(mkc(1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0)));
        cyc(16'hF6C0, 1'b1, 1'b0, "rst1");
        chk("rst_no_pcw", 32'(got.pc_write), 32'd0);
        chk("rst_ir", 32'(got_inst), 32'd0);
        reset_n = 1'b1;

        cyc(16'hF6C0, 1'b1, 1'b0, "add_if");
        chk("add_if_pcw", 32'({got.mem_read, got.pc_write, got.pc_src}), 32'b1100);
        cyc(16'hF6C0, 1'b1, 1'b0, "add_id");
        chk("add_id_ret", 32'(got.retire), 32'd0);
        cyc(16'hF6C0, 1'b1, 1'b0, "add_ex");
        chk("add_ex_alu", 32'({got.alu_src_a, got.alu_op}), 32'h10);
        cyc(16'hF6C0, 1'b1, 1'b0, "add_wb");
        chk("add_wb", 32'({got.reg_write, got.retire, got.reg_dst}), 32'b1101);

        cyc(16'h7102, 1'b1, 1'b0, "lwd_if");
        cyc(16'h7102, 1'b1, 1'b0, "lwd_id");
        cyc(16'h7102, 1'b1, 1'b0, "lwd_ex");
        for (int i = 0; i < 3; i++) begin
            cyc(16'h7102, 1'b0, 1'b0, "lwd_memwait");
            chk("lwd_mem_hold", 32'({got.mem_read, got.i_or_d, got.retire}), 32'b110);
        end
        cyc(16'h7102, 1'b1, 1'b0, "lwd_memrdy");
        chk("lwd_mem_done", 32'({got.mem_read, got.i_or_d, got.retire}), 32'b110);
        cyc(16'h7102, 1'b1, 1'b0, "lwd_wb");
        chk("lwd_wb", 32'({got.reg_write, got.mem_to_reg, got.retire}), 32'b1011);

        for (int c = 1; c >= 0; c--) begin
            cyc(16'h1105, 1'b1, 1'(c), "beq_if");
            cyc(16'h1105, 1'b1, 1'(c), "beq_id");
            cyc(16'h1105, 1'b1, 1'(c), "beq_ex");
            chk("beq_ex", 32'({got.pc_write, got.pc_src, got.retire}), c ? 32'b1011 : 32'b0011);
        end

        cyc(16'hA010, 1'b1, 1'b0, "jal_if");
        cyc(16'hA010, 1'b1, 1'b0, "jal_id");
        chk("jal_id", 32'({got.pc_write, got.pc_src, got.reg_write, got.reg_dst,
                           got.mem_to_reg, got.retire}), 32'b11011010_1);
        cyc(16'h0000, 1'b0, 1'b0, "jal_next");
        chk("jal_next_if", 32'({got.mem_read, got.i_or_d, got.pc_write}), 32'b100);

        for (int i = 0; i < 12; i++) begin
            int n;
            bit done;
            n = 0;
            done = 1'b0;
            while (!done && n < 12) begin
                cyc(vt[i].inst, 1'b1, vt[i].cond, $sformatf("vec%0d", i));
                n++;
                if (got.retire) done = 1'b1;
            end
            chk($sformatf("vec%0d_lat", i), 32'(n), 32'(vt[i].lat));
            chk($sformatf("vec%0d_last", i), 32'(got), 32'(vt[i].last));
        end

        cyc(16'hF01D, 1'b1, 1'b0, "hlt_if");
        cyc(16'hF01D, 1'b1, 1'b0, "hlt_id");
        chk("hlt_id_ret", 32'(got.retire), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cyc(16'($urandom), 1'($urandom_range(0, 1)), 1'b0, "hlt_stay");
            chk("hlt_stay", 32'({got.halted, got.illegal, got.mem_read, got.mem_write,
                                 got.reg_write}), 32'b10000);
        end
        reset_n = 1'b0;
        cyc(16'h0000, 1'b0, 1'b0, "hlt_rst");
        reset_n = 1'b1;
        cyc(16'hB000, 1'b1, 1'b0, "ill_if");
        cyc(16'hB000, 1'b1, 1'b0, "ill_id");
        chk("ill_id", 32'({got.retire, got.illegal}), 32'b00);
        for (int i = 0; i < 5; i++) begin
            cyc(16'hF6C0, 1'b1, 1'b0, "ill_stay");
            chk("ill_stay", 32'({got.halted, got.illegal, got.retire}), 32'b110);
        end
        reset_n = 1'b0;
        cyc(16'h0000, 1'b0, 1'b0, "ill_rst");
        chk("ill_cleared", 32'({got.halted, got.illegal}), 32'b00);
        reset_n = 1'b1;

        cyc(16'h8102, 1'b1, 1'b0, "swd_if");
        cyc(16'h8102, 1'b1, 1'b0, "swd_id");
        cyc(16'h8102, 1'b1, 1'b0, "swd_ex");
        cyc(16'h8102, 1'b0, 1'b0, "swd_mem");
        chk("swd_mem_wr", 32'(got.mem_write), 32'd1);
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("swd_rst_async", 32'({mem_write, mem_read, i_or_d}), 32'b010);
        @(posedge clk);
        #1;
        cyc(16'hF6C0, 1'b1, 1'b0, "swd_rst_hold");
        reset_n = 1'b1;
        cyc(16'hF6C0, 1'b1, 1'b0, "post_rst_if");
        chk("post_rst_fetch", 32'({got.mem_read, got.pc_write}), 32'b11);
        cyc(16'h0000, 1'b1, 1'b0, "post_rst_id");
        chk("post_rst_ir", 32'(got_inst), 32'hF6C0);

        halt_cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            reset_n = (halt_cnt >= 2 || $urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            cyc(rand_inst(), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", i));
            if (plan.size() > 0 && plan[0] == P_STOP) halt_cnt++;
            else halt_cnt = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
